imem_loader: RTL and testbench
==============================

# imem_loader

Hardware program loader for the pipelined CPU's instruction memory. It accepts a byte stream framed as a word-count header, payload words and an XOR checksum. It assembles big-endian 32-bit instructions and writes them into instruction memory at consecutive word addresses from 0. It holds the CPU in reset until a load completes with a good checksum, replacing the simulation-only memory preload with a synthesizable path.

## Interface
- IM_DEPTH, default 256: instruction-memory depth in words.
- ADDR_W, default 8: word-address width; must equal clog2(IM_DEPTH).
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- s_data_i  in  8  stream byte.
- s_valid_i  in  1  s_data_i is valid.
- s_ready_o  out  1  loader accepts a byte this cycle.
- im_we_o  out  1  instruction-memory write strobe.
- im_addr_o  out  ADDR_W  word address.
- im_wdata_o  out  32  instruction word.
- cpu_hold_o  out  1  high keeps the CPU in reset.
- done_o  out  1  load finished with a good checksum; level signal.
- err_o  out  1  load failed; level signal.

## Operation
- A transfer occurs when s_valid_i and s_ready_o are both high in the same cycle.
- Frame: N[15:8], N[7:0], then 4·N payload bytes (MSB first within each word), then one checksum byte C.
- C must equal the XOR of every preceding frame byte, header included.
- States:
  - IDLE: s_ready=0. start_i goes to HDR and clears the word counter, the byte counter and the running XOR.
  - HDR: s_ready=1. Accepts 2 bytes. After the second byte: if N>IM_DEPTH, go to ERR; if N=0, go to CHK; otherwise go to DATA.
  - DATA: s_ready=1. Shifts bytes into a 32-bit assembly register. On the 4th byte of a word, register the write: im_addr=word index, im_wdata=assembled word. The word index increments. After word N−1, go to CHK.
  - CHK: s_ready=1. Accepts 1 byte. If it matches the running XOR, go to DONE; otherwise go to ERR.
  - DONE: s_ready=0, done_o=1, cpu_hold_o=0. start_i goes to HDR.
  - ERR: s_ready=1 and incoming bytes are discarded (the stream drains). err_o=1. start_i goes to HDR.
- cpu_hold_o=1 in every state except DONE.
- start_i is ignored in HDR, DATA and CHK.
- Words already written before an ERR stay in memory; the CPU stays held.
- The word counter is ADDR_W+1 bits wide, so N=IM_DEPTH is legal and the final address is IM_DEPTH−1 with no wrap.

## Timing
- Reset values: state=IDLE, s_ready_o=0, im_we_o=0, im_addr_o=0, im_wdata_o=0, cpu_hold_o=1, done_o=0, err_o=0.
- im_we_o is a 1-cycle pulse in the cycle after the 4th byte of a word is accepted. Address and data are valid in that same cycle.
- Back-to-back bytes are accepted at 1 byte per cycle with no stall. s_ready_o never drops mid-frame.
- start_i in cycle t makes s_ready_o high in cycle t+1.
- The transition to DONE or ERR is registered in the cycle the checksum byte is accepted, so done_o/err_o rise 1 cycle later. cpu_hold_o falls together with done_o rising.
- A rst_i assertion at any point, including mid-word, forces the reset values on the next edge. A partial word is never written.
- s_valid_i while s_ready_o=0 is ignored, and no byte is consumed.

## Structure
- A shared package holds:
  - the state enum (IDLE, HDR, DATA, CHK, DONE, ERR);
  - the header length constant (2);
  - the bytes-per-word constant (4).
- One natural sub-module, loader_word_asm: the byte-to-word shift register plus a 2-bit byte counter, with a word_valid pulse output. The FSM, counters and XOR stay in imem_loader.

## Test plan
- Good load: N=2, words 0x20010005 and 0x8C020000, correct C. Expect 2 writes, addr 0 and 1, exact data; done_o=1; cpu_hold_o=0.
- Bad checksum: same frame with C^0x01. Expect 2 writes, then err_o=1, cpu_hold_o=1, done_o=0. A following start_i with a good frame ends in done_o=1.
- Empty load: N=0, C=0x00. Expect no im_we_o pulses; done_o=1 two bytes after start plus the checksum byte.
- Oversize: N=257 with IM_DEPTH=256. Expect err_o=1 after the header and no writes. Extra bytes are accepted and discarded.
- Full memory: N=256, word i = i. Expect the last write at addr 255 with data 0x000000FF, then done_o=1.
- Gapped stream with reset mid-word: s_valid_i toggles every other cycle and data stays correct. rst_i asserted after 2 bytes of word 3 gives the reset values on the next edge and no write to addr 3.

Source files
------------

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Purpose  : Shared types and constants for the instruction-memory loader.
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  // Loader sequencing states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  // Word-count header is two bytes, MSB first
  localparam int HDR_BYTES      = 2;
  // Instructions are 32-bit, sent big-endian
  localparam int BYTES_PER_WORD = 4;

endpackage
`default_nettype wire

// File: rtl/imem_loader_word_asm.sv
`default_nettype none
// ============================================================================
// Module   : loader_word_asm
// Purpose  : Big-endian byte-to-word assembler. Emits a one-cycle word_valid
//            together with the complete word while the 4th byte is presented.
// Revision : 1.0 - initial release
// ============================================================================
module loader_word_asm
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  // Only the first three bytes need storage; the 4th is taken straight
  // from the input so the full word is available in its arrival cycle.
  logic [23:0] upper;
  logic [1:0]  byte_cnt;

  assign word       = {upper, byte_in};
  assign word_valid = shift_en && (byte_cnt == 2'(BYTES_PER_WORD - 1));

  // Shift accepted bytes in MSB first and count position within the word
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      upper    <= '0;
      byte_cnt <= '0;
    end else if (shift_en) begin
      upper    <= {upper[15:0], byte_in};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Loads a framed byte stream (count header, payload, XOR checksum)
//            into instruction memory and holds the CPU in reset until a load
//            completes with a good checksum.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IM_DEPTH = 256,
  parameter int ADDR_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [7:0]        s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic              im_we_o,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [31:0]       im_wdata_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              err_o
);

  // One extra bit so a full-depth load counts to IM_DEPTH without wrapping
  localparam int CNT_W = ADDR_W + 1;

  state_t           state;
  logic             hdr_cnt;
  logic [7:0]       n_hi;
  logic [15:0]      n_words;
  logic [CNT_W-1:0] word_cnt;
  logic [7:0]       csum;

  logic             xfer;
  logic [15:0]      n_full;
  logic [CNT_W-1:0] word_cnt_nx;
  logic             can_start;
  logic             clr_asm;
  logic             shift_en;
  logic [31:0]      asm_word;
  logic             asm_valid;

  assign xfer        = s_valid_i && s_ready_o;
  assign n_full      = {n_hi, s_data_i};
  assign word_cnt_nx = word_cnt + 1'b1;
  assign can_start   = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
  assign clr_asm     = can_start && start_i;
  assign shift_en    = xfer && (state == ST_DATA);

  loader_word_asm u_word_asm (
    .clk        (clk_i),
    .rst        (rst_i),
    .clr        (clr_asm),
    .shift_en   (shift_en),
    .byte_in    (s_data_i),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  // Frame sequencer with registered handshake and status outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      s_ready_o  <= 1'b0;
      cpu_hold_o <= 1'b1;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      hdr_cnt    <= 1'b0;
      n_hi       <= '0;
      n_words    <= '0;
      word_cnt   <= '0;
      csum       <= '0;
    end else begin
      case (state)
        ST_HDR: begin
          if (xfer) begin
            csum <= csum ^ s_data_i;
            if (hdr_cnt != 1'(HDR_BYTES - 1)) begin
              n_hi    <= s_data_i;
              hdr_cnt <= 1'b1;
            end else begin
              n_words <= n_full;
              if ({16'd0, n_full} > 32'(IM_DEPTH)) begin
                // Stream stays ready in ERR so the oversize payload drains
                state <= ST_ERR;
                err_o <= 1'b1;
              end else if (n_full == 16'd0) begin
                state <= ST_CHK;
              end else begin
                state <= ST_DATA;
              end
            end
          end
        end
        ST_DATA: begin
          if (xfer) begin
            csum <= csum ^ s_data_i;
            if (asm_valid) begin
              word_cnt <= word_cnt_nx;
              if (16'(word_cnt_nx) == n_words) begin
                state <= ST_CHK;
              end
            end
          end
        end
        ST_CHK: begin
          if (xfer) begin
            if (s_data_i == csum) begin
              state      <= ST_DONE;
              s_ready_o  <= 1'b0;
              done_o     <= 1'b1;
              cpu_hold_o <= 1'b0;
            end else begin
              state <= ST_ERR;
              err_o <= 1'b1;
            end
          end
        end
        default: begin
          // IDLE, DONE and ERR all restart a load on start_i
          if (start_i) begin
            state      <= ST_HDR;
            s_ready_o  <= 1'b1;
            cpu_hold_o <= 1'b1;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            hdr_cnt    <= 1'b0;
            word_cnt   <= '0;
            csum       <= '0;
          end
        end
      endcase
    end
  end

  // Memory write port: strobe, address and data registered together
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      im_we_o    <= 1'b0;
      im_addr_o  <= '0;
      im_wdata_o <= '0;
    end else begin
      im_we_o <= asm_valid;
      if (asm_valid) begin
        im_addr_o  <= word_cnt[ADDR_W-1:0];
        im_wdata_o <= asm_word;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Scoreboard bench for imem_loader with randomized frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int stalls   = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] words[256];

  imem_loader #(.IM_DEPTH(256), .ADDR_W(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .s_data_i   (s_data),
    .s_valid_i  (s_valid),
    .s_ready_o  (s_ready),
    .im_we_o    (im_we),
    .im_addr_o  (im_addr),
    .im_wdata_o (im_wdata),
    .cpu_hold_o (cpu_hold),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next expected write
  always @(posedge clk) begin
    #2;
    if (im_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", im_addr, im_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", {24'd0, im_addr}, {24'd0, e.addr});
        check("write_data", im_wdata, e.data);
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_im_we", {31'd0, im_we}, 32'd0);
    check("rst_im_addr", {24'd0, im_addr}, 32'd0);
    check("rst_im_wdata", im_wdata, 32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
  endtask

  // All tasks begin and end just after a falling edge
  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && w < 50) begin
      @(negedge clk);
      w++;
      stalls++;
    end
    if (w >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got s_ready 0 for 50 cycles, expected 1");
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = 8'($urandom);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ready_after_start", {31'd0, s_ready}, 32'd1);
    check("done_clear_on_start", {31'd0, done}, 32'd0);
    check("err_clear_on_start", {31'd0, err}, 32'd0);
    stalls = 0;
  endtask

  task automatic run_frame(input int n, input bit corrupt, input bit gapped);
    logic [7:0]  bytes[$];
    logic [7:0]  x;
    logic [31:0] w;
    wr_t         e;
    bytes.push_back(8'(n >> 8));
    bytes.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      w = words[i];
      bytes.push_back(w[31:24]);
      bytes.push_back(w[23:16]);
      bytes.push_back(w[15:8]);
      bytes.push_back(w[7:0]);
      e.addr = 8'(i);
      e.data = w;
      exp_q.push_back(e);
    end
    x = 8'h00;
    foreach (bytes[k]) x ^= bytes[k];
    bytes.push_back(corrupt ? (x ^ 8'h01) : x);
    do_start();
    foreach (bytes[k]) begin
      if (gapped && k > 0) @(negedge clk);
      send_byte(bytes[k]);
    end
    check("frame_done", {31'd0, done}, {31'd0, !corrupt});
    check("frame_err", {31'd0, err}, {31'd0, corrupt});
    check("frame_hold", {31'd0, cpu_hold}, {31'd0, corrupt});
    check("frame_no_stall", stalls, 32'd0);
    repeat (2) @(negedge clk);
    check("writes_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    wr_t e;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);

    // Good load
    words[0] = 32'h20010005;
    words[1] = 32'h8C020000;
    run_frame(2, 1'b0, 1'b0);
    // Bad checksum, then recovery
    run_frame(2, 1'b1, 1'b0);
    run_frame(2, 1'b0, 1'b0);
    // Empty load
    run_frame(0, 1'b0, 1'b0);

    // Oversize header: error right after header, payload drains
    do_start();
    send_byte(8'h01);
    send_byte(8'h01);
    check("oversize_err", {31'd0, err}, 32'd1);
    check("oversize_done", {31'd0, done}, 32'd0);
    check("oversize_hold", {31'd0, cpu_hold}, 32'd1);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom));
    check("oversize_drain_no_stall", stalls, 32'd0);
    check("oversize_no_writes", exp_q.size(), 32'd0);

    // Full memory
    for (int i = 0; i < 256; i++) words[i] = 32'(i);
    run_frame(256, 1'b0, 1'b0);

    // Randomized frames, some gapped, some corrupted
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) words[i] = $urandom;
      run_frame(n, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    // Gapped stream, reset after two bytes of word 3
    for (int i = 0; i < 5; i++) words[i] = $urandom;
    do_start();
    send_byte(8'h00);
    @(negedge clk);
    send_byte(8'h05);
    for (int i = 0; i < 3; i++) begin
      e.addr = 8'(i);
      e.data = words[i];
      exp_q.push_back(e);
      for (int b = 3; b >= 0; b--) begin
        @(negedge clk);
        send_byte(8'(words[i] >> (8 * b)));
      end
    end
    @(negedge clk);
    send_byte(8'(words[3] >> 24));
    @(negedge clk);
    send_byte(8'(words[3] >> 16));
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midword_reset_no_write", exp_q.size(), 32'd0);
    check("midword_reset_hold", {31'd0, cpu_hold}, 32'd1);

    // Clean load after reset
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    run_frame(3, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
